// File: rtl/keychain_initiator.sv
// keychain_initiator: sends key then message bytes over UART 8N1 and collects a MSG_BYTES response.
// Define KEYCHAIN_INIT_TIMEOUT_EN to abort when the responder stays silent for TIMEOUT_CLKS cycles.
module keychain_initiator #(
   parameter int KEY_BYTES    = 2,
   parameter int MSG_BYTES    = 1,
   parameter int BAUD_RATE    = 115_200,
   parameter int CLK_HZ       = 100_000_000,
   parameter int TIMEOUT_CLKS = 10_000_000
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   req_valid_in,
   output logic                   req_ready_out,
   input  logic [8*KEY_BYTES-1:0] key_in,
   input  logic [8*MSG_BYTES-1:0] msg_in,
   output logic                   tx_wire_out,
   input  logic                   rx_wire_in,
   output logic                   resp_valid_out,
   output logic [8*MSG_BYTES-1:0] resp_data_out,
   output logic                   err_out
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int TOT_BYTES    = KEY_BYTES + MSG_BYTES;
   localparam int TX_W         = 8 * TOT_BYTES;
   localparam int RESP_W       = 8 * MSG_BYTES;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);
   localparam int BYTE_W       = $clog2(TOT_BYTES + 1);
   localparam int RB_W         = $clog2(MSG_BYTES + 1);

   if (CLKS_PER_BIT < 2) begin : g_bad_baud
      $error("CLK_HZ/BAUD_RATE must be at least 2");
   end
   if (TIMEOUT_CLKS < 1) begin : g_bad_timeout
      $error("TIMEOUT_CLKS must be positive");
   end

   typedef enum logic [2:0] {IDLE, SEND_KEY, SEND_MSG, WAIT_RESP, DONE} state_t;

   state_t              state_q, state_d;
   logic                ready_q, ready_d;
   logic                tx_q, tx_d;
   logic [TX_W-1:0]     tx_buf_q, tx_buf_d;
   logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
   logic [3:0]          tx_bit_q, tx_bit_d;
   logic [BYTE_W-1:0]   tx_byte_q, tx_byte_d;
   logic                rx_s1_q, rx_s2_q, rx_prev_q;
   logic                rx_busy_q, rx_busy_d;
   logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;
   logic [3:0]          rx_bit_q, rx_bit_d;
   logic [7:0]          rx_shift_q, rx_shift_d;
   logic                rx_byte_vld, rx_frame_err, rx_fall;
   logic [RB_W-1:0]     rx_bytes_q, rx_bytes_d;
   logic [RESP_W-1:0]   resp_buf_q, resp_buf_d;
   logic [RESP_W-1:0]   resp_data_q, resp_data_d;
   logic                resp_valid_q, resp_valid_d;
   logic                err_q, err_d;
   logic                accept;

   // Line level for frame position idx: 0 start, 1..8 data LSB first, 9 stop.
   function automatic logic frame_bit(input logic [7:0] b, input logic [3:0] idx);
      logic [7:0] sh;
      sh = b >> (idx - 4'd1);
      if (idx == 4'd0)      return 1'b0;
      else if (idx >= 4'd9) return 1'b1;
      else                  return sh[0];
   endfunction

   always_comb begin
      rx_fall      = rx_prev_q & ~rx_s2_q;
      rx_busy_d    = rx_busy_q;
      rx_cnt_d     = rx_cnt_q;
      rx_bit_d     = rx_bit_q;
      rx_shift_d   = rx_shift_q;
      rx_byte_vld  = 1'b0;
      rx_frame_err = 1'b0;
      if (!rx_busy_q) begin
         if (rx_fall) begin
            rx_busy_d = 1'b1;
            rx_cnt_d  = CNT_W'(HALF_BIT - 1);
            rx_bit_d  = 4'd0;
         end
      end else if (rx_cnt_q != '0) begin
         rx_cnt_d = rx_cnt_q - 1'b1;
      end else begin
         rx_cnt_d = CNT_W'(CLKS_PER_BIT - 1);
         if (rx_bit_q == 4'd0) begin
            // A glitch that is high again at mid-bit is not a start bit.
            if (rx_s2_q) rx_busy_d = 1'b0;
            else         rx_bit_d  = 4'd1;
         end else if (rx_bit_q <= 4'd8) begin
            rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
            rx_bit_d   = rx_bit_q + 4'd1;
         end else begin
            rx_busy_d = 1'b0;
            if (rx_s2_q) rx_byte_vld  = 1'b1;
            else         rx_frame_err = 1'b1;
         end
      end
   end

`ifdef KEYCHAIN_INIT_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d;

   always_comb begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (state_q != WAIT_RESP || rx_byte_vld) to_cnt_d = '0;
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) to_cnt_q <= '0;
      else        to_cnt_q <= to_cnt_d;
   end
`endif

   always_comb begin
      accept       = req_valid_in & ready_q;
      state_d      = state_q;
      tx_d         = tx_q;
      tx_buf_d     = tx_buf_q;
      tx_cnt_d     = tx_cnt_q;
      tx_bit_d     = tx_bit_q;
      tx_byte_d    = tx_byte_q;
      rx_bytes_d   = rx_bytes_q;
      resp_buf_d   = resp_buf_q;
      resp_data_d  = resp_data_q;
      resp_valid_d = 1'b0;
      err_d        = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               tx_buf_d   = {key_in, msg_in};
               tx_d       = 1'b0;
               tx_cnt_d   = '0;
               tx_bit_d   = 4'd0;
               tx_byte_d  = '0;
               rx_bytes_d = '0;
               resp_buf_d = '0;
               state_d    = SEND_KEY;
            end
         end
         SEND_KEY, SEND_MSG: begin
            if (tx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 4'd9) begin
                  tx_bit_d  = 4'd0;
                  tx_byte_d = tx_byte_q + 1'b1;
                  tx_buf_d  = tx_buf_q << 8;
                  if (tx_byte_q == BYTE_W'(TOT_BYTES - 1)) begin
                     tx_d    = 1'b1;
                     state_d = WAIT_RESP;
                  end else begin
                     // Next start bit follows the stop bit with no idle gap.
                     tx_d = 1'b0;
                     if (tx_byte_q == BYTE_W'(KEY_BYTES - 1)) state_d = SEND_MSG;
                  end
               end else begin
                  tx_bit_d = tx_bit_q + 4'd1;
                  tx_d     = frame_bit(tx_buf_q[TX_W-1 -: 8], tx_bit_q + 4'd1);
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         WAIT_RESP: begin
            if (rx_byte_vld) begin
               resp_buf_d = (resp_buf_q << 8) | RESP_W'(rx_shift_q);
               rx_bytes_d = rx_bytes_q + 1'b1;
               if (rx_bytes_q == RB_W'(MSG_BYTES - 1)) begin
                  state_d      = DONE;
                  resp_data_d  = resp_buf_d;
                  resp_valid_d = 1'b1;
               end
            end else if (rx_frame_err) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
`ifdef KEYCHAIN_INIT_TIMEOUT_EN
            else if (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1)) begin
               state_d = IDLE;
               err_d   = 1'b1;
            end
`endif
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q      <= IDLE;
         ready_q      <= 1'b0;
         tx_q         <= 1'b1;
         tx_buf_q     <= '0;
         tx_cnt_q     <= '0;
         tx_bit_q     <= 4'd0;
         tx_byte_q    <= '0;
         rx_s1_q      <= 1'b1;
         rx_s2_q      <= 1'b1;
         rx_prev_q    <= 1'b1;
         rx_busy_q    <= 1'b0;
         rx_cnt_q     <= '0;
         rx_bit_q     <= 4'd0;
         rx_shift_q   <= '0;
         rx_bytes_q   <= '0;
         resp_buf_q   <= '0;
         resp_data_q  <= '0;
         resp_valid_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         ready_q      <= ready_d;
         tx_q         <= tx_d;
         tx_buf_q     <= tx_buf_d;
         tx_cnt_q     <= tx_cnt_d;
         tx_bit_q     <= tx_bit_d;
         tx_byte_q    <= tx_byte_d;
         rx_s1_q      <= rx_wire_in;
         rx_s2_q      <= rx_s1_q;
         rx_prev_q    <= rx_s2_q;
         rx_busy_q    <= rx_busy_d;
         rx_cnt_q     <= rx_cnt_d;
         rx_bit_q     <= rx_bit_d;
         rx_shift_q   <= rx_shift_d;
         rx_bytes_q   <= rx_bytes_d;
         resp_buf_q   <= resp_buf_d;
         resp_data_q  <= resp_data_d;
         resp_valid_q <= resp_valid_d;
         err_q        <= err_d;
      end
   end

   assign req_ready_out  = ready_q;
   assign tx_wire_out    = tx_q;
   assign resp_valid_out = resp_valid_q;
   assign resp_data_out  = resp_data_q;
   assign err_out        = err_q;
endmodule
